// File: rtl/uart_host_scheduler_pkg.sv
// Shared op codes, rate codes and FSM state encoding for the UART host scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        RATE_DEFAULT = 2'b00,
        RATE_9600    = 2'b01,
        RATE_50000   = 2'b10,
        RATE_115200  = 2'b11
    } rate_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

endpackage

// File: rtl/uart_host_scheduler_rr_arbiter.sv
// Two-requester round-robin arbiter; grant is combinational, pointer toggles on each accept.
module rr_arbiter (
    input  logic       clk,
    input  logic       nReset,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_id,
    output logic       accept
);

    logic ptr;

    always_comb begin
        grant_id = (valid == 2'b11) ? ptr : ~valid[0];
        grant    = 2'b00;
        if (enable) begin
            grant = (grant_id ? 2'b10 : 2'b01) & valid;
        end
        accept = |grant;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/uart_host_scheduler.sv
// Schedules ops from two requesters onto a UART wrapper with an ISSUE cycle followed by an idle GAP.
module uart_host_scheduler
    import uart_sched_pkg::*;
#(
    parameter int IdleGap = 1
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic [1:0]      req_valid,
    input  logic [1:0][1:0] req_op,
    input  logic [1:0][7:0] req_wdata,
    output logic [1:0]      req_ready,
    output logic [1:0]      rsp_valid,
    output logic [7:0]      rsp_data,
    input  logic [1:0]      cfg_rate,
    input  logic            cfg_we,
    output logic [3:0]      control,
    output logic [7:0]      tx_data,
    input  logic [7:0]      rx_data,
    output logic            busy
);

    state_e      state, next_state;
    op_e         op_lat;
    logic        id_lat;
    logic [3:0]  gap_cnt;
    logic [1:0]  pend_rate;
    logic [1:0]  act_rate;
    logic        grant_id;
    logic        accept;

    rr_arbiter u_arb (
        .clk      (clk),
        .nReset   (nReset),
        .valid    (req_valid),
        .enable   (state == ST_IDLE),
        .grant    (req_ready),
        .grant_id (grant_id),
        .accept   (accept)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_GAP;
            ST_GAP:   if (gap_cnt <= 4'd1) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            op_lat  <= OP_NOP;
            id_lat  <= 1'b0;
            tx_data <= 8'h00;
        end else if (accept) begin
            op_lat  <= op_e'(req_op[grant_id]);
            id_lat  <= grant_id;
            tx_data <= req_wdata[grant_id];
        end
    end

    // Counter reloads while in ISSUE so it holds IdleGap on the first GAP cycle; it saturates at 0.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            gap_cnt <= 4'd0;
        end else if (state == ST_ISSUE) begin
            gap_cnt <= 4'(IdleGap);
        end else if (state == ST_GAP && gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rsp_valid <= 2'b00;
            rsp_data  <= 8'h00;
        end else if (state == ST_GAP && gap_cnt == 4'(IdleGap)) begin
            rsp_valid <= id_lat ? 2'b10 : 2'b01;
            rsp_data  <= (op_lat == OP_READ) ? rx_data : 8'h00;
        end else begin
            rsp_valid <= 2'b00;
            rsp_data  <= 8'h00;
        end
    end

    // The active rate only follows the pending one while idle, so an op never sees a rate change.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            pend_rate <= 2'b00;
            act_rate  <= 2'b00;
        end else begin
            if (cfg_we) pend_rate <= cfg_rate;
            if (state == ST_IDLE) act_rate <= cfg_we ? cfg_rate : pend_rate;
        end
    end

    always_comb begin
        control = {(state == ST_ISSUE) ? op_lat : OP_NOP, act_rate};
        busy    = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_host_scheduler.sv
// Directed table-driven bench for uart_host_scheduler with hand-written reset and rate sequences.
module tb_uart_host_scheduler;

    logic            clk;
    logic            nReset;
    logic [1:0]      req_valid;
    logic [1:0][1:0] req_op;
    logic [1:0][7:0] req_wdata;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [7:0]      rsp_data;
    logic [1:0]      cfg_rate;
    logic            cfg_we;
    logic [3:0]      control;
    logic [7:0]      tx_data;
    logic [7:0]      rx_data;
    logic            busy;

    int n_tests;
    int n_fail;

    uart_host_scheduler #(.IdleGap(1)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .cfg_rate  (cfg_rate),
        .cfg_we    (cfg_we),
        .control   (control),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] valid;
        logic [1:0] op0;
        logic [1:0] op1;
        logic [7:0] wd0;
        logic [7:0] wd1;
        logic [7:0] rx;
        logic [1:0] ready;
        logic [3:0] ctrl;
        logic [7:0] tx;
        logic [1:0] rsp;
        logic [7:0] rspd;
        logic       bsy;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {7'd0, req_ready, control, tx_data, rsp_valid, rsp_data, busy};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] o0, input logic [1:0] o1,
                         input logic [7:0] w0, input logic [7:0] w1);
        req_valid    = v;
        req_op[0]    = o0;
        req_op[1]    = o1;
        req_wdata[0] = w0;
        req_wdata[1] = w1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        cfg_rate = 2'b00;
        cfg_we   = 1'b0;
        rx_data  = 8'h00;
        nReset   = 1'b0;

        // valid op0 op1 wd0 wd1 rx | ready ctrl tx rsp rspd busy
        tbl[0]  = '{2'b01, 2'b01, 2'b00, 8'hA5, 8'h00, 8'h00, 2'b01, 4'h0, 8'h00, 2'b00, 8'h00, 1'b0};
        tbl[1]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 4'h4, 8'hA5, 2'b00, 8'h00, 1'b1};
        tbl[2]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'hFF, 2'b00, 4'h0, 8'hA5, 2'b00, 8'h00, 1'b1};
        tbl[3]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 8'hA5, 2'b01, 8'h00, 1'b0};
        tbl[4]  = '{2'b10, 2'b00, 2'b10, 8'h00, 8'h11, 8'h00, 2'b10, 4'h0, 8'hA5, 2'b00, 8'h00, 1'b0};
        tbl[5]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 4'h8, 8'h11, 2'b00, 8'h00, 1'b1};
        tbl[6]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h3C, 2'b00, 4'h0, 8'h11, 2'b00, 8'h00, 1'b1};
        tbl[7]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 8'h11, 2'b10, 8'h3C, 1'b0};
        tbl[8]  = '{2'b11, 2'b01, 2'b01, 8'h01, 8'h02, 8'h00, 2'b01, 4'h0, 8'h11, 2'b00, 8'h00, 1'b0};
        tbl[9]  = '{2'b11, 2'b01, 2'b01, 8'h01, 8'h02, 8'h00, 2'b00, 4'h4, 8'h01, 2'b00, 8'h00, 1'b1};
        tbl[10] = '{2'b11, 2'b01, 2'b01, 8'h01, 8'h02, 8'h00, 2'b00, 4'h0, 8'h01, 2'b00, 8'h00, 1'b1};
        tbl[11] = '{2'b11, 2'b01, 2'b01, 8'h01, 8'h02, 8'h00, 2'b10, 4'h0, 8'h01, 2'b01, 8'h00, 1'b0};
        tbl[12] = '{2'b11, 2'b01, 2'b01, 8'h01, 8'h02, 8'h00, 2'b00, 4'h4, 8'h02, 2'b00, 8'h00, 1'b1};
        tbl[13] = '{2'b11, 2'b01, 2'b01, 8'h01, 8'h02, 8'h00, 2'b00, 4'h0, 8'h02, 2'b00, 8'h00, 1'b1};
        tbl[14] = '{2'b11, 2'b01, 2'b01, 8'h01, 8'h02, 8'h00, 2'b01, 4'h0, 8'h02, 2'b10, 8'h00, 1'b0};
        tbl[15] = '{2'b11, 2'b01, 2'b01, 8'h01, 8'h02, 8'h00, 2'b00, 4'h4, 8'h01, 2'b00, 8'h00, 1'b1};
        tbl[16] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 8'h01, 2'b00, 8'h00, 1'b1};
        tbl[17] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 8'h01, 2'b01, 8'h00, 1'b0};
        tbl[18] = '{2'b01, 2'b11, 2'b00, 8'h5A, 8'h00, 8'h00, 2'b01, 4'h0, 8'h01, 2'b00, 8'h00, 1'b0};
        tbl[19] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 4'hC, 8'h5A, 2'b00, 8'h00, 1'b1};
        tbl[20] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 8'h5A, 2'b00, 8'h00, 1'b1};
        tbl[21] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 8'h5A, 2'b01, 8'h00, 1'b0};
        tbl[22] = '{2'b10, 2'b00, 2'b00, 8'h00, 8'h77, 8'h00, 2'b10, 4'h0, 8'h5A, 2'b00, 8'h00, 1'b0};
        tbl[23] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 8'h77, 2'b00, 8'h00, 1'b1};
        tbl[24] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'hEE, 2'b00, 4'h0, 8'h77, 2'b00, 8'h00, 1'b1};
        tbl[25] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 8'h77, 2'b10, 8'h00, 1'b0};

        #3;
        chk("reset_outputs", outs(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        nReset = 1'b1;
        next_cycle();

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].valid, tbl[i].op0, tbl[i].op1, tbl[i].wd0, tbl[i].wd1);
            rx_data = tbl[i].rx;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(),
                {7'd0, tbl[i].ready, tbl[i].ctrl, tbl[i].tx, tbl[i].rsp, tbl[i].rspd, tbl[i].bsy});
            next_cycle();
        end

        // Rate written during ISSUE must not reach control until after an IDLE cycle.
        drive(2'b01, 2'b01, 2'b00, 8'h42, 8'h00);
        @(negedge clk);
        chk("rate_accept_ready", {30'd0, req_ready}, 32'h1);
        next_cycle();
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        cfg_rate = 2'b11;
        cfg_we   = 1'b1;
        @(negedge clk);
        chk("rate_issue_ctrl", {28'd0, control}, 32'h4);
        next_cycle();
        cfg_we = 1'b0;
        @(negedge clk);
        chk("rate_gap_ctrl", {28'd0, control}, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rate_after_idle", {28'd0, control}, 32'h3);
        next_cycle();

        // Reset in the GAP of a READ drops the op.
        drive(2'b10, 2'b00, 2'b10, 8'h00, 8'h00);
        @(negedge clk);
        chk("rst_read_ready", {30'd0, req_ready}, 32'h2);
        next_cycle();
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        next_cycle();
        rx_data = 8'h99;
        #2;
        nReset = 1'b0;
        #1;
        chk("rst_async_outputs", outs(), 32'd0);
        next_cycle();
        chk("rst_no_rsp", {22'd0, rsp_valid, rsp_data}, 32'd0);
        #3;
        nReset  = 1'b1;
        rx_data = 8'h00;
        next_cycle();

        drive(2'b01, 2'b01, 2'b00, 8'h3D, 8'h00);
        @(negedge clk);
        chk("post_rst_ready", {30'd0, req_ready}, 32'h1);
        next_cycle();
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        @(negedge clk);
        chk("post_rst_issue", {20'd0, control, tx_data}, 32'h43D);
        next_cycle();
        @(negedge clk);
        chk("post_rst_gap", {29'd0, rsp_valid, busy}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("post_rst_rsp", {21'd0, rsp_valid, rsp_data, busy}, 32'h200);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
